// File: rtl/ifu_fetch_if.sv
// Instruction-memory bus between the fetch unit and the instruction array.
// master (ifu): drives im_addr, receives im_data; slave (memory): the reverse.
interface ifu_fetch_if;
   logic [12:0] im_addr;
   logic [31:0] im_data;

   modport master (output im_addr, input im_data);
   modport slave  (input im_addr, output im_data);
endinterface

// File: rtl/ifu_fetch.sv
// Fetch stage: PC register, combinational instruction-memory read, F/D register.
// Ports: clk, reset (sync, active-high), stall, br_taken/br_target, exc_req,
//   eret/epc, im (instruction bus master), pc_F, instr_D, pc_D, valid_D, adel_D.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_PC   = 32'h0000_4180,
   parameter logic [31:0] IM_LO    = 32'h0000_3000,
   parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
   ifu_fetch_if.master im,
   output logic [31:0] pc_F,
   output logic [31:0] instr_D,
   output logic [31:0] pc_D,
   output logic        valid_D,
   output logic        adel_D
);

   logic        fetch_adel;
   logic [31:0] fetch_word;

   // Illegal fetches are parked on the base word so no read leaves the array.
   always_comb begin
      fetch_adel = (pc_F[1:0] != 2'b00) || (pc_F < IM_LO) || (pc_F > IM_HI);
      im.im_addr = fetch_adel ? 13'hC00 : pc_F[14:2];
      fetch_word = fetch_adel ? 32'h0 : im.im_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_F    <= RESET_PC;
         instr_D <= 32'h0;
         pc_D    <= 32'h0;
         valid_D <= 1'b0;
         adel_D  <= 1'b0;
      end else if (exc_req || eret) begin
         // Redirect with bubble; eret has no delay slot.
         pc_F    <= exc_req ? EXC_PC : epc;
         instr_D <= 32'h0;
         pc_D    <= 32'h0;
         valid_D <= 1'b0;
         adel_D  <= 1'b0;
      end else if (!stall) begin
         // A taken branch keeps the current fetch as its delay slot.
         pc_F    <= br_taken ? br_target : pc_F + 32'd4;
         instr_D <= fetch_word;
         pc_D    <= pc_F;
         valid_D <= 1'b1;
         adel_D  <= fetch_adel;
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized self-checking bench for ifu_fetch against a behavioural model.
// Directed scenarios first, then random redirects, stalls, exceptions, resets.
module tb_ifu_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC   = 32'h0000_4180;
   localparam logic [31:0] IM_LO    = 32'h0000_3000;
   localparam logic [31:0] IM_HI    = 32'h0000_6FFC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = 32'h0;
   logic        exc_req = 1'b0;
   logic        eret = 1'b0;
   logic [31:0] epc = 32'h0;
   logic [31:0] pc_F, instr_D, pc_D;
   logic        valid_D, adel_D;

   logic [31:0] mem [0:8191];

   ifu_fetch_if im_bus ();
   assign im_bus.im_data = mem[im_bus.im_addr];

   ifu_fetch #(
      .RESET_PC(RESET_PC), .EXC_PC(EXC_PC), .IM_LO(IM_LO), .IM_HI(IM_HI)
   ) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .br_taken(br_taken), .br_target(br_target),
      .exc_req(exc_req), .eret(eret), .epc(epc),
      .im(im_bus.master),
      .pc_F(pc_F), .instr_D(instr_D), .pc_D(pc_D),
      .valid_D(valid_D), .adel_D(adel_D)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [31:0] m_pc, m_ins, m_pcd;
   logic        m_vd, m_ad;

   function automatic bit legal(input logic [31:0] a);
      return (a % 4 == 0) && (a >= IM_LO) && (a <= IM_HI);
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return mem[(a / 4) % 8192];
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".pc_F"}, pc_F, m_pc);
      chk({tag, ".instr_D"}, instr_D, m_ins);
      chk({tag, ".pc_D"}, pc_D, m_pcd);
      chk({tag, ".valid_D"}, {31'b0, valid_D}, {31'b0, m_vd});
      chk({tag, ".adel_D"}, {31'b0, adel_D}, {31'b0, m_ad});
      chk({tag, ".im_addr"}, {19'b0, im_bus.im_addr},
          legal(m_pc) ? (m_pc / 4) % 8192 : 32'hC00);
   endtask

   task automatic step(input string tag, input bit rs, input bit st,
                       input bit bt, input logic [31:0] bta, input bit ex,
                       input bit er, input logic [31:0] ep);
      @(negedge clk);
      reset = rs; stall = st; br_taken = bt; br_target = bta;
      exc_req = ex; eret = er; epc = ep;
      if (rs) begin
         m_pc = RESET_PC; m_ins = 0; m_pcd = 0; m_vd = 0; m_ad = 0;
      end else if (ex || er) begin
         m_pc = ex ? EXC_PC : ep;
         m_ins = 0; m_pcd = 0; m_vd = 0; m_ad = 0;
      end else if (!st) begin
         m_ins = legal(m_pc) ? word_at(m_pc) : 32'h0;
         m_pcd = m_pc;
         m_vd  = 1'b1;
         m_ad  = !legal(m_pc);
         m_pc  = bt ? bta : m_pc + 32'd4;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   logic [31:0] tgt;
   int r;

   initial begin
      for (int i = 0; i < 8192; i++)
         mem[i] = 32'h1000_0000 + i - 32'hC00;
      m_pc = 0; m_ins = 0; m_pcd = 0; m_vd = 0; m_ad = 0;

      step("rst", 1, 0, 0, 0, 0, 0, 0);
      chk("rst.pc_F", pc_F, 32'h3000);
      chk("rst.im_addr", {19'b0, im_bus.im_addr}, 32'hC00);
      chk("rst.valid_D", {31'b0, valid_D}, 32'h0);

      step("free0", 0, 0, 0, 0, 0, 0, 0);
      chk("free0.pc_D", pc_D, 32'h3000);
      chk("free0.instr_D", instr_D, 32'h1000_0000);
      step("free1", 0, 0, 0, 0, 0, 0, 0);
      chk("free1.instr_D", instr_D, 32'h1000_0001);
      chk("free1.pc_F", pc_F, 32'h3008);

      step("br", 0, 0, 1, 32'h3100, 0, 0, 0);
      chk("br.slot_pc_D", pc_D, 32'h3008);
      chk("br.instr_D", instr_D, 32'h1000_0002);
      chk("br.pc_F", pc_F, 32'h3100);
      step("br1", 0, 0, 0, 0, 0, 0, 0);
      chk("br1.pc_D", pc_D, 32'h3100);

      step("stl0", 0, 1, 1, 32'h3200, 0, 0, 0);
      step("stl1", 0, 1, 1, 32'h3200, 0, 0, 0);
      chk("stl.pc_F", pc_F, 32'h3104);
      chk("stl.pc_D", pc_D, 32'h3100);
      step("rel", 0, 0, 0, 0, 0, 0, 0);
      chk("rel.pc_F", pc_F, 32'h3108);

      step("exc", 0, 1, 0, 0, 1, 1, 32'h3010);
      chk("exc.pc_F", pc_F, 32'h4180);
      chk("exc.valid_D", {31'b0, valid_D}, 32'h0);
      step("eret", 0, 0, 0, 0, 0, 1, 32'h3010);
      chk("eret.pc_F", pc_F, 32'h3010);

      step("mis", 0, 0, 1, 32'h3002, 0, 0, 0);
      chk("mis.im_addr", {19'b0, im_bus.im_addr}, 32'hC00);
      step("mis1", 0, 0, 1, 32'h7000, 0, 0, 0);
      chk("mis1.adel_D", {31'b0, adel_D}, 32'h1);
      chk("mis1.pc_D", pc_D, 32'h3002);
      chk("oor.im_addr", {19'b0, im_bus.im_addr}, 32'hC00);
      step("oor1", 0, 0, 0, 0, 0, 1, 32'h2FFC);
      chk("lo.im_addr", {19'b0, im_bus.im_addr}, 32'hC00);
      step("lo1", 0, 0, 0, 0, 0, 0, 0);
      chk("lo1.adel_D", {31'b0, adel_D}, 32'h1);
      chk("lo1.instr_D", instr_D, 32'h0);
      chk("lo1.pc_D", pc_D, 32'h2FFC);

      step("rst_exc", 1, 1, 1, 32'h3100, 1, 0, 0);
      chk("rst_exc.pc_F", pc_F, 32'h3000);
      chk("rst_exc.pc_D", pc_D, 32'h0);

      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         case ($urandom_range(0, 3))
            0: tgt = IM_LO + ($urandom_range(0, 32'h3FFF) & ~32'h3);
            1: tgt = IM_LO + $urandom_range(0, 32'h3FFF);
            2: tgt = $urandom;
            default: tgt = IM_HI - 4 * $urandom_range(0, 3);
         endcase
         step("rnd", r < 2, $urandom_range(0, 99) < 20,
              $urandom_range(0, 99) < 25, tgt,
              $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 5, tgt);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000: PC value after reset, and first fetch address.
REQ-002 Parameter EXC_PC, 32'h0000_4180: exception handler entry address.
REQ-003 Parameter IM_LO, 32'h0000_3000: lowest legal fetch byte address.
REQ-004 Parameter IM_HI, 32'h0000_6FFC: highest legal fetch byte address.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 stall  in  1  hold PC and the F/D register.
REQ-008 br_taken  in  1  branch/jump redirect from D stage.
REQ-009 br_target  in  32  byte address for the redirect.
REQ-010 exc_req  in  1  exception/interrupt taken; vector to EXC_PC.
REQ-011 eret  in  1  return from exception; vector to epc.
REQ-012 epc  in  32  return address for eret.
REQ-013 im_addr  out  13  word index to instruction memory (byte address bits [14:2]).
REQ-014 im_data  in  32  combinational instruction word from memory.
REQ-015 pc_F  out  32  current fetch PC.
REQ-016 instr_D  out  32  registered instruction for D stage.
REQ-017 pc_D  out  32  registered PC of instr_D.
REQ-018 valid_D  out  1  instr_D is a real fetched instruction, not a bubble.
REQ-019 adel_D  out  1  instr_D fetch raised an address error (AdEL).

Function
REQ-020 The block SHALL be the fetch-side initiator of the instruction memory: a combinational read with zero-cycle latency, addressed by PC, with no memory write path.
REQ-021 The fetch is legal when pc_F[1:0]==0 and IM_LO<=pc_F<=IM_HI; otherwise it raises fetch_adel.
REQ-022 When the fetch is legal, im_addr SHALL equal pc_F[14:2]; on fetch_adel, im_addr SHALL be 13'hC00 so no read leaves the array.
REQ-023 Fetched word SHALL be im_data when legal, 32'h0 (nop) on fetch_adel.
REQ-024 Next-PC priority per edge: reset > exc_req > eret > stall > br_taken > pc_F+4.
REQ-025 exc_req: PC<=EXC_PC; F/D register loads bubble (instr_D=0, pc_D=0, valid_D=0, adel_D=0); stall is ignored.
REQ-026 eret (without exc_req): PC<=epc; F/D loads bubble; stall is ignored; eret has no delay slot.
REQ-027 stall (no exc_req/eret): PC and all D outputs hold their values; br_taken is ignored this cycle.
REQ-028 br_taken (no stall): PC<=br_target; F/D loads the current fetch, which is the delay slot and is not flushed.
REQ-029 Normal advance: PC<=pc_F+4 (32-bit wrap, unsigned); F/D loads {fetched word, pc_F, valid=1, fetch_adel}.
REQ-030 A misaligned or out-of-range br_target/epc SHALL be accepted into PC; the error is flagged on the following fetch via adel_D.
REQ-031 pc_F SHALL reflect only the PC register; the PC SHALL have no combinational bypass of next-PC.

Reset
REQ-032 On reset, the block SHALL set pc_F=RESET_PC, instr_D=0, pc_D=0, valid_D=0, adel_D=0, overriding every other input.
REQ-033 With reset asserted mid-stall or mid-redirect, the state SHALL equal post-reset state on the next edge.
REQ-034 The first cycle after reset deassertion SHALL fetch from RESET_PC (im_addr=13'hC00).

Verification
REQ-035 Reset then 3 free cycles, memory word k = 32'h1000_0000+k -> pc_D sequence 3000, 3004, 3008; instr_D 1000_0000, 1000_0001, 1000_0002; valid_D=1.
REQ-036 br_taken=1, br_target=3100 at pc_F=3008 -> next pc_D=3008 (delay slot kept), then pc_F=3100, then pc_D=3100.
REQ-037 stall=1 for 2 cycles together with br_taken=1 -> pc_F and D outputs frozen, branch dropped; release -> pc_F+4 resumes.
REQ-038 exc_req=1 with stall=1 and eret=1 -> pc_F=4180, valid_D=0, instr_D=0; eret alone with epc=3010 -> pc_F=3010, bubble in D.
REQ-039 br_target=3002, then br_target=7000, then eret to 2FFC -> each following fetch gives adel_D=1, instr_D=0, im_addr=C00, pc_D=offending address.
REQ-040 reset asserted in the same cycle as exc_req -> pc_F=3000 and all D outputs 0.
